// File: rtl/alu_pkg.sv
// Shared types and constants for the binary32 floating-point ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int EXP_BIAS    = 127;
  // Widest significand handed to the normaliser: the full 24x24 product.
  localparam int NORM_W      = 48;
  // Signed internal exponent; wide enough for eA+eB and eA-eB+bias minus a full shift.
  localparam int EXP_W       = 12;
  // Quotient bits produced by the restoring divider (1 integer bit + 25 fraction bits).
  localparam int QUO_W       = 26;
  // Alignment shifts at or beyond this leave the larger operand untouched.
  localparam int ALIGN_LIMIT = 25;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;   // true zero or flushed subnormal
    logic        is_sub;
    logic [23:0] mant;      // significand with hidden bit; 0 for zero/subnormal
  } fp_class_t;

  function automatic fp_class_t classify(input fp32_t x);
    fp_class_t c;
    c.is_nan  = (x.exp == 8'hFF) && (x.frac != 23'd0);
    c.is_inf  = (x.exp == 8'hFF) && (x.frac == 23'd0);
    c.is_zero = (x.exp == 8'h00);
    c.is_sub  = (x.exp == 8'h00) && (x.frac != 23'd0);
    c.mant    = (x.exp == 8'h00) ? 24'd0 : {1'b1, x.frac};
    return c;
  endfunction

  function automatic logic signed [EXP_W-1:0] widen_exp(input logic [7:0] e);
    return $signed({{(EXP_W-8){1'b0}}, e});
  endfunction

  function automatic logic [31:0] signed_inf(input logic s);
    return {s, 8'hFF, 23'd0};
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'd0};
  endfunction

endpackage

// File: rtl/fp_normalize.sv
// Leading-zero normaliser with truncation and overflow/underflow clamping.
// exp_i is the biased exponent that bit NORM_W-1 of sig_i would carry.
module fp_normalize
  import alu_pkg::*;
(
  input  logic                    sign_i,
  input  logic [NORM_W-1:0]       sig_i,
  input  logic signed [EXP_W-1:0] exp_i,
  output logic [31:0]             result_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int LZ_W = $clog2(NORM_W + 1);

  logic [LZ_W-1:0]         lz;
  logic [22:0]             frac;
  logic signed [EXP_W-1:0] exp_norm;

  // Priority encoder: distance from the MSB to the highest set bit.
  always_comb begin
    lz = LZ_W'(NORM_W);
    for (int i = 0; i < NORM_W; i++) begin
      if (sig_i[i]) lz = LZ_W'(NORM_W - 1 - i);
    end
  end

  // Bits below the hidden one after the shift; everything further down is discarded.
  assign frac     = 23'((sig_i << lz) >> (NORM_W - 24));
  assign exp_norm = exp_i - $signed({{(EXP_W-LZ_W){1'b0}}, lz});

  // Pack the result, clamping exponents that fall outside the normal range.
  always_comb begin
    result_o    = {sign_i, exp_norm[7:0], frac};
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    if (sig_i == '0) begin
      result_o = 32'd0;
    end else if (exp_norm >= EXP_W'(255)) begin
      result_o   = signed_inf(sign_i);
      overflow_o = 1'b1;
    end else if (exp_norm <= EXP_W'(0)) begin
      result_o    = signed_zero(sign_i);
      underflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu.sv
// Binary32 add/sub/mul/div with one registered output stage and status flags.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] n1,
  input  logic [31:0] n2,
  input  logic [1:0]  oper,
  output logic [31:0] result,
  output logic        Overflow,
  output logic        Underflow,
  output logic        Exception
);

  fp32_t     a, b;
  fp_class_t ca, cb;
  op_e       op;
  logic      b_sign_eff;
  logic      prod_sign;
  logic      in_sub;

  assign a          = fp32_t'(n1);
  assign b          = fp32_t'(n2);
  assign ca         = classify(a);
  assign cb         = classify(b);
  assign op         = op_e'(oper);
  assign b_sign_eff = (op == OP_SUB) ? ~b.sign : b.sign;
  assign prod_sign  = a.sign ^ b.sign;
  assign in_sub     = ca.is_sub | cb.is_sub;

  // ---------------- add / subtract path ----------------
  logic                    a_is_big;
  logic                    big_sign, small_sign;
  logic [7:0]              big_exp, small_exp, exp_diff;
  logic [23:0]             big_mant, small_mant, small_aligned;
  logic [24:0]             add_sum;
  logic signed [EXP_W-1:0] add_exp;

  // Order by magnitude so a subtraction never goes negative.
  assign a_is_big      = {a.exp, ca.mant} >= {b.exp, cb.mant};
  assign big_sign      = a_is_big ? a.sign   : b_sign_eff;
  assign small_sign    = a_is_big ? b_sign_eff : a.sign;
  assign big_exp       = a_is_big ? a.exp    : b.exp;
  assign small_exp     = a_is_big ? b.exp    : a.exp;
  assign big_mant      = a_is_big ? ca.mant  : cb.mant;
  assign small_mant    = a_is_big ? cb.mant  : ca.mant;
  assign exp_diff      = big_exp - small_exp;
  assign small_aligned = (exp_diff >= 8'(ALIGN_LIMIT)) ? 24'd0 : (small_mant >> exp_diff);
  assign add_sum       = (big_sign ^ small_sign) ? ({1'b0, big_mant} - {1'b0, small_aligned})
                                                 : ({1'b0, big_mant} + {1'b0, small_aligned});
  // add_sum bit 24 sits one binade above the larger operand's hidden bit.
  assign add_exp       = widen_exp(big_exp) + EXP_W'(1);

  // ---------------- multiply path ----------------
  logic [47:0]             mul_prod;
  logic signed [EXP_W-1:0] mul_exp;

  assign mul_prod = {24'd0, ca.mant} * {24'd0, cb.mant};
  // Product bit 47 is worth 2^1 relative to the hidden bits.
  assign mul_exp  = widen_exp(a.exp) + widen_exp(b.exp) - EXP_W'(EXP_BIAS - 1);

  // ---------------- divide path ----------------
  logic [24:0]             div_rem [0:QUO_W-1];
  logic [QUO_W-1:0]        div_quo;
  logic signed [EXP_W-1:0] div_exp;

  assign div_rem[0] = {1'b0, ca.mant};

  // Unrolled restoring divider: one quotient bit per stage, MSB (2^0) first.
  // A kept remainder is always below the divisor, so 24 bits hold it before the shift.
  generate
    for (genvar gi = 0; gi < QUO_W; gi++) begin : g_div_stage
      assign div_quo[QUO_W-1-gi] = (div_rem[gi] >= {1'b0, cb.mant});
      if (gi < QUO_W - 1) begin : g_next
        logic [23:0] diff;
        assign diff            = div_rem[gi][23:0] - cb.mant;
        assign div_rem[gi + 1] = {(div_quo[QUO_W-1-gi] ? diff : div_rem[gi][23:0]), 1'b0};
      end
    end
  endgenerate

  // Quotient bit QUO_W-1 carries weight 2^0.
  assign div_exp = widen_exp(a.exp) - widen_exp(b.exp) + EXP_W'(EXP_BIAS);

  // ---------------- shared normaliser ----------------
  logic                    norm_sign;
  logic [NORM_W-1:0]       norm_sig;
  logic signed [EXP_W-1:0] norm_exp;
  logic [31:0]             norm_result;
  logic                    norm_overflow, norm_underflow;

  // Route the active datapath into the single normaliser.
  always_comb begin
    norm_sign = big_sign;
    norm_sig  = {add_sum, {(NORM_W-25){1'b0}}};
    norm_exp  = add_exp;
    case (op)
      OP_MUL: begin
        norm_sign = prod_sign;
        norm_sig  = mul_prod;
        norm_exp  = mul_exp;
      end
      OP_DIV: begin
        norm_sign = prod_sign;
        norm_sig  = {div_quo, {(NORM_W-QUO_W){1'b0}}};
        norm_exp  = div_exp;
      end
      default: ;
    endcase
  end

  fp_normalize u_norm (
    .sign_i      (norm_sign),
    .sig_i       (norm_sig),
    .exp_i       (norm_exp),
    .result_o    (norm_result),
    .overflow_o  (norm_overflow),
    .underflow_o (norm_underflow)
  );

  // ---------------- special operands ----------------
  logic        special;
  logic [31:0] special_result;
  logic        special_ovf, special_exc;

  // Resolve NaN/inf/zero operands in priority order; defaults describe an invalid op.
  always_comb begin
    special        = 1'b1;
    special_result = QNAN;
    special_ovf    = 1'b0;
    special_exc    = 1'b1;
    if (!(ca.is_nan || cb.is_nan)) begin
      case (op)
        OP_ADD, OP_SUB: begin
          if (ca.is_inf && cb.is_inf && (a.sign != b_sign_eff)) begin
            special = 1'b1;
          end else if (ca.is_inf) begin
            special_result = signed_inf(a.sign);
            special_ovf    = 1'b1;
            special_exc    = 1'b0;
          end else if (cb.is_inf) begin
            special_result = signed_inf(b_sign_eff);
            special_ovf    = 1'b1;
            special_exc    = 1'b0;
          end else begin
            special = 1'b0;
          end
        end
        OP_MUL: begin
          if ((ca.is_inf && cb.is_zero) || (ca.is_zero && cb.is_inf)) begin
            special = 1'b1;
          end else if (ca.is_inf || cb.is_inf) begin
            special_result = signed_inf(prod_sign);
            special_ovf    = 1'b1;
            special_exc    = 1'b0;
          end else if (ca.is_zero || cb.is_zero) begin
            special_result = signed_zero(prod_sign);
            special_exc    = 1'b0;
          end else begin
            special = 1'b0;
          end
        end
        default: begin
          if ((ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
            special = 1'b1;
          end else if (cb.is_zero && !ca.is_inf) begin
            special_result = signed_inf(prod_sign);
          end else if (ca.is_inf) begin
            special_result = signed_inf(prod_sign);
            special_ovf    = 1'b1;
            special_exc    = 1'b0;
          end else if (cb.is_inf || ca.is_zero) begin
            special_result = signed_zero(prod_sign);
            special_exc    = 1'b0;
          end else begin
            special = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------- output registers ----------------
  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        underflow_d, underflow_q;
  logic        exception_d, exception_q;

  // Pick special or normalised outcome; flushed subnormal inputs always flag Underflow.
  always_comb begin
    result_d    = norm_result;
    overflow_d  = norm_overflow;
    underflow_d = norm_underflow | in_sub;
    exception_d = 1'b0;
    if (special) begin
      result_d    = special_result;
      overflow_d  = special_ovf;
      underflow_d = in_sub;
      exception_d = special_exc;
    end
  end

  // Single pipeline stage holding result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= 32'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      exception_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      exception_q <= exception_d;
    end
  end

  assign result    = result_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
  assign Exception = exception_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the binary32 ALU: directed vectors plus random ops vs a value model.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] n1, n2;
  logic [1:0]  oper;
  logic [31:0] result;
  logic        Overflow, Underflow, Exception;

  int n_checks = 0;
  int n_errors = 0;
  int txn_no   = 0;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .n1        (n1),
    .n2        (n2),
    .oper      (oper),
    .result    (result),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Exception (Exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed expectation layout: {Overflow, Underflow, Exception, result}
  task automatic check_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got O/U/E=%b result=%h, required O/U/E=%b result=%h",
               tag, got[34:32], got[31:0], exp[34:32], exp[31:0]);
    end
  endtask

  // Value of m * 2^scale, truncated to a 24-bit significand and packed.
  function automatic logic [34:0] pack_value(input logic s, input longint unsigned m, input int scale);
    int p;
    int e;
    longint unsigned f;
    if (m == 0) return 35'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    e = p + scale + 127;
    if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b010, s, 31'd0};
    f = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
    return {3'b000, s, e[7:0], f[22:0]};
  endfunction

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic sa, sb, sbe, sp;
    int ea, eb, el, es;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, subf;
    longint unsigned ma, mb, ml, msh, al, sum;
    logic sl;
    logic [34:0] r;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    subf   = (a_zero && a[22:0] != 0) || (b_zero && b[22:0] != 0);
    ma = a_zero ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = b_zero ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    sbe = (op == 2'b01) ? ~sb : sb;
    sp  = sa ^ sb;
    if (a_nan || b_nan) begin
      r = {3'b001, 32'h7FC00000};
    end else if (op[1] == 1'b0) begin
      if (a_inf && b_inf && (sa != sbe))      r = {3'b001, 32'h7FC00000};
      else if (a_inf)                         r = {3'b100, sa, 8'hFF, 23'd0};
      else if (b_inf)                         r = {3'b100, sbe, 8'hFF, 23'd0};
      else begin
        if (ea > eb || (ea == eb && ma >= mb)) begin
          ml = ma; el = ea; sl = sa;  msh = mb; es = eb;
        end else begin
          ml = mb; el = eb; sl = sbe; msh = ma; es = ea;
        end
        al  = (el - es >= 25) ? 0 : (msh >> (el - es));
        sum = (sa == sbe) ? ml + al : ml - al;
        r   = pack_value(sl, sum, el - 150);
        if (sum == 0) r = 35'd0;
      end
    end else if (op == 2'b10) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) r = {3'b001, 32'h7FC00000};
      else if (a_inf || b_inf)                    r = {3'b100, sp, 8'hFF, 23'd0};
      else if (a_zero || b_zero)                  r = {3'b000, sp, 31'd0};
      else                                        r = pack_value(sp, ma * mb, ea + eb - 300);
    end else begin
      if ((a_zero && b_zero) || (a_inf && b_inf)) r = {3'b001, 32'h7FC00000};
      else if (b_zero && !a_inf)                  r = {3'b001, sp, 8'hFF, 23'd0};
      else if (a_inf)                             r = {3'b100, sp, 8'hFF, 23'd0};
      else if (b_inf || a_zero)                   r = {3'b000, sp, 31'd0};
      else                                        r = pack_value(sp, (ma << 25) / mb, ea - eb - 25);
    end
    r[33] = r[33] | subf;
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic       s;
    logic [7:0] e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 8));
      3:       e = 8'($urandom_range(246, 254));
      4:       e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // One clock per transaction: drive, let the edge sample, then look 1 time unit later.
  task automatic do_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic r, input logic [34:0] exp);
    n1 = a; n2 = b; oper = op; rst = r;
    @(posedge clk);
    #1;
    $display("txn %0d %s: rst=%b op=%0d n1=%h n2=%h -> result=%h O=%b U=%b E=%b",
             txn_no, tag, r, op, a, b, result, Overflow, Underflow, Exception);
    txn_no++;
    check_eq(tag, {Overflow, Underflow, Exception, result}, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [34:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] ra, rb;
  logic [1:0]  rop;

  initial begin
    rst = 1'b1; n1 = '0; n2 = '0; oper = '0;

    // Reset holds outputs at zero even with a live operation on the inputs.
    do_txn("reset_1", 32'h4236B000, 32'h41BC7000, 2'b00, 1'b1, 35'd0);
    do_txn("reset_2", 32'h4236B000, 32'h41BC7000, 2'b10, 1'b1, 35'd0);

    vecs.push_back('{"add",          32'h4236B000, 32'h41BC7000, 2'b00, {3'b000, 32'h428A7400}});
    vecs.push_back('{"sub",          32'h4236B000, 32'h41BC7000, 2'b01, {3'b000, 32'h41B0F000}});
    vecs.push_back('{"mul",          32'h4236B000, 32'h41BC7000, 2'b10, {3'b000, 32'h4486792D}});
    vecs.push_back('{"div",          32'h4236B000, 32'h40000000, 2'b11, {3'b000, 32'h41B6B000}});
    vecs.push_back('{"inf_add",      32'h7F800000, 32'h3F800000, 2'b00, {3'b100, 32'h7F800000}});
    vecs.push_back('{"sub_inputs",   32'h00000001, 32'h00000001, 2'b00, {3'b010, 32'h00000000}});
    vecs.push_back('{"div_zero",     32'h4236B000, 32'h00000000, 2'b11, {3'b001, 32'h7F800000}});
    vecs.push_back('{"inf_sub_inf",  32'h7F800000, 32'h7F800000, 2'b01, {3'b001, 32'h7FC00000}});
    vecs.push_back('{"mul_ovf",      32'h7F000000, 32'h40000000, 2'b10, {3'b100, 32'h7F800000}});
    vecs.push_back('{"mul_unf",      32'h00800000, 32'h3F000000, 2'b10, {3'b010, 32'h00000000}});
    vecs.push_back('{"align_24",     32'h4B800000, 32'h3F800000, 2'b00, {3'b000, 32'h4B800000}});
    vecs.push_back('{"cancel",       32'h3F800000, 32'h3F800000, 2'b01, {3'b000, 32'h00000000}});
    vecs.push_back('{"zero_mul_neg", 32'h00000000, 32'hBF800000, 2'b10, {3'b000, 32'h80000000}});
    vecs.push_back('{"nan_mul",      32'h7F800001, 32'h00000000, 2'b10, {3'b001, 32'h7FC00000}});
    vecs.push_back('{"div_by_inf",   32'hC0000000, 32'h7F800000, 2'b11, {3'b000, 32'h80000000}});
    vecs.push_back('{"zero_mul_inf", 32'h80000000, 32'h7F800000, 2'b10, {3'b001, 32'h7FC00000}});

    // Directed vectors issued back to back, one per cycle.
    foreach (vecs[i]) do_txn(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, vecs[i].exp);

    // Reset in the middle of a stream clears outputs, then operation resumes.
    do_txn("pre_reset", 32'h4236B000, 32'h41BC7000, 2'b00, 1'b0, {3'b000, 32'h428A7400});
    do_txn("mid_reset", 32'h7F800000, 32'h3F800000, 2'b00, 1'b1, 35'd0);
    do_txn("post_reset", 32'h4236B000, 32'h41BC7000, 2'b01, 1'b0, {3'b000, 32'h41B0F000});

    // Random operations against the value model; some pairs share exponents to force cancellation.
    for (int t = 0; t < 240; t++) begin
      ra  = rand_fp();
      rb  = ($urandom_range(0, 5) == 0) ? (ra ^ 32'($urandom_range(0, 4095))) : rand_fp();
      rop = 2'($urandom_range(0, 3));
      do_txn("random", ra, rb, rop, 1'b0, model(ra, rb, rop));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
